// File: rtl/noc_rc_pkg.sv
// Shared definitions for the route/VC-request controller: FSM state encoding
// and the width of the drained-packet counter.
package noc_rc_pkg;

   localparam int unsigned DropCntW = 8;
   localparam logic [DropCntW-1:0] DropCntMax = '1;

   typedef enum logic [2:0] {
      StIdle,
      StRcWait,
      StVaWait,
      StActive,
      StDrain
   } noc_rc_state_e;

endpackage

// File: rtl/rc_retry_timer.sv
// Routing-request retry timer. Counts qualifying idle cycles while a route
// result is outstanding; o_expire fires on the cycle that completes Timeout
// counts, and the count restarts from zero afterwards.
// Only instantiated when VC_ROUTE_REQUESTER_RC_RETRY_EN is defined.
module rc_retry_timer
   import noc_rc_pkg::*;
#(
   parameter int unsigned Timeout = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expire
);

   localparam int unsigned CntW = $clog2(Timeout + 1);

   logic [CntW-1:0] r_cnt;

   assign o_expire = i_count && !i_clear && (r_cnt == CntW'(Timeout - 1));

   // Idle-cycle counter; wraps to zero on clear or when the timeout is reached.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear || o_expire) begin
         r_cnt <= '0;
      end else if (i_count) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

endmodule

// File: rtl/vc_route_requester.sv
// Per-input-port route/VC-request controller. Captures a head flit, pulses
// rc_req to the routing unit, latches the result, requests a VC and then
// follows the packet to its tail. Packets routed to an empty port set are
// drained and counted (saturating).
// Optional feature: define VC_ROUTE_REQUESTER_RC_RETRY_EN to re-issue rc_req
// after rc_timeout silent cycles in RC_WAIT.
module vc_route_requester
   import noc_rc_pkg::*;
#(
   parameter int unsigned no_outport = 6,
   parameter int unsigned no_vc      = 13,
   parameter int unsigned flit_size  = 1,
   parameter int unsigned phit_size  = 16,
   parameter int unsigned rc_timeout = 15
) (
   input  logic                            clk,
   input  logic                            rs,
   input  logic [flit_size*phit_size-1:0]  header_in,
   input  logic                            head_valid,
   output logic [flit_size*phit_size-1:0]  rc_header,
   output logic                            rc_req,
   input  logic                            rc_valid,
   input  logic [no_outport-1:0]           outport_vec,
   input  logic [no_vc-1:0]                allow_vcs,
   output logic                            va_req,
   output logic [no_outport-1:0]           va_outport,
   output logic [no_vc-1:0]                va_allow_vcs,
   input  logic                            va_grant,
   input  logic                            flit_valid,
   input  logic                            flit_tail,
   output logic                            flit_fwd,
   output logic                            flit_drop,
   output logic                            route_busy,
   output logic [DropCntW-1:0]             drop_cnt
);

   noc_rc_state_e r_state;

   logic w_rc_accept;
   logic w_retry;
   logic w_tail_seen;

   // A result arriving during the request pulse belongs to a stale exchange.
   assign w_rc_accept = (r_state == StRcWait) && !rc_req && rc_valid;
   assign w_tail_seen = flit_valid && flit_tail;

   assign flit_fwd   = (r_state == StActive) && flit_valid;
   assign flit_drop  = (r_state == StDrain) && flit_valid;
   assign route_busy = (r_state != StIdle);

`ifdef VC_ROUTE_REQUESTER_RC_RETRY_EN
   rc_retry_timer #(
      .Timeout (rc_timeout)
   ) u_retry_timer (
      .i_clk    (clk),
      .i_rst_n  (rs),
      .i_clear  ((r_state != StRcWait) || rc_req),
      .i_count  ((r_state == StRcWait) && !rc_req && !rc_valid),
      .o_expire (w_retry)
   );
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^rc_timeout;
   assign w_retry      = 1'b0;
`endif

   // Control FSM with registered request outputs and result latches.
   always_ff @(posedge clk or negedge rs) begin
      if (!rs) begin
         r_state      <= StIdle;
         rc_header    <= '0;
         rc_req       <= 1'b0;
         va_req       <= 1'b0;
         va_outport   <= '0;
         va_allow_vcs <= '0;
         drop_cnt     <= '0;
      end else begin
         rc_req <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (head_valid) begin
                  rc_header <= header_in;
                  rc_req    <= 1'b1;
                  r_state   <= StRcWait;
               end
            end
            StRcWait: begin
               if (w_rc_accept) begin
                  va_outport   <= outport_vec;
                  va_allow_vcs <= allow_vcs;
                  if (outport_vec == '0) begin
                     r_state <= StDrain;
                     if (drop_cnt != DropCntMax) begin
                        drop_cnt <= drop_cnt + DropCntW'(1);
                     end
                  end else begin
                     va_req  <= 1'b1;
                     r_state <= StVaWait;
                  end
               end else if (w_retry) begin
                  rc_req <= 1'b1;
               end
            end
            StVaWait: begin
               if (va_grant) begin
                  va_req  <= 1'b0;
                  r_state <= StActive;
               end
            end
            StActive, StDrain: begin
               if (w_tail_seen) begin
                  r_state <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
               va_req  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vc_route_requester.sv
// Self-checking bench for vc_route_requester. Packets are described as
// transactions (header, RC latency, route, grant delay, flit count) and the
// expected observations come from the documented handshake timing.
module tb_vc_route_requester;

   logic        clk = 1'b0;
   logic        rs  = 1'b1;
   logic [15:0] header_in = '0;
   logic        head_valid = 1'b0;
   logic [15:0] rc_header;
   logic        rc_req;
   logic        rc_valid = 1'b0;
   logic [5:0]  outport_vec = '0;
   logic [12:0] allow_vcs = '0;
   logic        va_req;
   logic [5:0]  va_outport;
   logic [12:0] va_allow_vcs;
   logic        va_grant = 1'b0;
   logic        flit_valid = 1'b0;
   logic        flit_tail = 1'b0;
   logic        flit_fwd;
   logic        flit_drop;
   logic        route_busy;
   logic [7:0]  drop_cnt;

   vc_route_requester #(
      .no_outport (6),
      .no_vc      (13),
      .flit_size  (1),
      .phit_size  (16),
      .rc_timeout (15)
   ) dut (
      .clk          (clk),
      .rs           (rs),
      .header_in    (header_in),
      .head_valid   (head_valid),
      .rc_header    (rc_header),
      .rc_req       (rc_req),
      .rc_valid     (rc_valid),
      .outport_vec  (outport_vec),
      .allow_vcs    (allow_vcs),
      .va_req       (va_req),
      .va_outport   (va_outport),
      .va_allow_vcs (va_allow_vcs),
      .va_grant     (va_grant),
      .flit_valid   (flit_valid),
      .flit_tail    (flit_tail),
      .flit_fwd     (flit_fwd),
      .flit_drop    (flit_drop),
      .route_busy   (route_busy),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int          n_checks  = 0;
   int          n_fail    = 0;
   int          exp_drops = 0;
   logic [5:0]  exp_vo    = '0;
   logic [12:0] exp_vv    = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_head(input logic [15:0] h, input logic stale);
      check_eq("idle_busy", 32'(route_busy), 32'(0));
      check_eq("idle_va_outport", 32'(va_outport), 32'(exp_vo));
      check_eq("idle_va_allow", 32'(va_allow_vcs), 32'(exp_vv));
      check_eq("idle_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
      head_valid = 1'b1;
      header_in  = h;
      rc_valid   = 1'b0;
      flit_valid = 1'($urandom);
      flit_tail  = 1'($urandom);
      va_grant   = 1'($urandom);
      #1;
      check_eq("idle_fwd", 32'(flit_fwd), 32'(0));
      check_eq("idle_drop", 32'(flit_drop), 32'(0));
      tick();
      check_eq("rc_req_pulse", 32'(rc_req), 32'(1));
      check_eq("rc_header", 32'(rc_header), 32'(h));
      check_eq("rc_busy", 32'(route_busy), 32'(1));
      check_eq("rc_no_va_req", 32'(va_req), 32'(0));
      head_valid  = 1'($urandom);
      header_in   = 16'($urandom);
      flit_valid  = 1'b0;
      rc_valid    = stale;
      outport_vec = 6'($urandom);
      allow_vcs   = 13'($urandom);
      tick();
   endtask

   task automatic rc_answer(input int delay, input logic [5:0] vec, input logic [12:0] vcs);
      for (int k = 1; k <= delay; k++) begin
         check_eq("rc_req_single", 32'(rc_req), 32'(0));
         check_eq("rc_wait_va_req", 32'(va_req), 32'(0));
         rc_valid    = (k == delay);
         outport_vec = (k == delay) ? vec : 6'($urandom);
         allow_vcs   = (k == delay) ? vcs : 13'($urandom);
         flit_valid  = 1'($urandom);
         flit_tail   = 1'($urandom);
         va_grant    = 1'($urandom);
         head_valid  = 1'($urandom);
         #1;
         check_eq("rc_wait_fwd", 32'(flit_fwd), 32'(0));
         check_eq("rc_wait_drop", 32'(flit_drop), 32'(0));
         tick();
      end
      rc_valid   = 1'b0;
      flit_valid = 1'b0;
      va_grant   = 1'b0;
      head_valid = 1'b0;
      exp_vo = vec;
      exp_vv = vcs;
      if (vec == '0 && exp_drops < 255) exp_drops++;
      check_eq("latched_outport", 32'(va_outport), 32'(exp_vo));
      check_eq("latched_allow", 32'(va_allow_vcs), 32'(exp_vv));
      check_eq("va_req_raise", 32'(va_req), 32'(vec != '0));
      check_eq("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
      check_eq("rc_req_low", 32'(rc_req), 32'(0));
   endtask

   task automatic va_phase(input int gdelay);
      for (int k = 1; k <= gdelay; k++) begin
         check_eq("va_req_hold", 32'(va_req), 32'(1));
         check_eq("va_outport_hold", 32'(va_outport), 32'(exp_vo));
         check_eq("va_allow_hold", 32'(va_allow_vcs), 32'(exp_vv));
         va_grant   = (k == gdelay);
         flit_valid = 1'($urandom);
         flit_tail  = 1'($urandom);
         head_valid = 1'($urandom);
         rc_valid   = 1'($urandom);
         #1;
         check_eq("va_wait_fwd", 32'(flit_fwd), 32'(0));
         tick();
      end
      va_grant   = 1'b0;
      rc_valid   = 1'b0;
      head_valid = 1'b0;
      flit_valid = 1'b0;
      check_eq("va_req_drop", 32'(va_req), 32'(0));
      check_eq("active_busy", 32'(route_busy), 32'(1));
   endtask

   task automatic data_phase(input int n, input logic drain);
      int sent = 0;
      int seen = 0;
      while (sent < n) begin
         flit_valid = ($urandom_range(0, 3) != 0);
         flit_tail  = flit_valid ? (sent == n - 1) : 1'($urandom);
         va_grant   = 1'($urandom);
         head_valid = 1'($urandom);
         #1;
         check_eq("data_busy", 32'(route_busy), 32'(1));
         check_eq("flit_fwd", 32'(flit_fwd), 32'(flit_valid && !drain));
         check_eq("flit_drop", 32'(flit_drop), 32'(flit_valid && drain));
         if (flit_fwd || flit_drop) seen++;
         if (flit_valid) sent++;
         tick();
      end
      flit_valid = 1'b0;
      flit_tail  = 1'b0;
      va_grant   = 1'b0;
      head_valid = 1'b0;
      check_eq("flit_pulses", 32'(seen), 32'(n));
      check_eq("tail_idle", 32'(route_busy), 32'(0));
      check_eq("tail_rc_req", 32'(rc_req), 32'(0));
      check_eq("tail_va_req", 32'(va_req), 32'(0));
   endtask

   task automatic pkt(input logic [15:0] h, input logic stale, input int rdelay,
                      input logic [5:0] vec, input logic [12:0] vcs, input int gdelay,
                      input int n);
      send_head(h, stale);
      rc_answer(rdelay, vec, vcs);
      if (vec != '0) va_phase(gdelay);
      data_phase(n, vec == '0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] rv;
      #1 rs = 1'b0;
      #3;
      check_eq("rst_rc_req", 32'(rc_req), 32'(0));
      check_eq("rst_va_req", 32'(va_req), 32'(0));
      check_eq("rst_busy", 32'(route_busy), 32'(0));
      check_eq("rst_drop_cnt", 32'(drop_cnt), 32'(0));
      check_eq("rst_va_outport", 32'(va_outport), 32'(0));
      check_eq("rst_va_allow", 32'(va_allow_vcs), 32'(0));
      check_eq("rst_rc_header", 32'(rc_header), 32'(0));
      #8 rs = 1'b1;
      tick();

      // Directed: routed packet with 3 body flits and a tail.
      pkt(16'h1234, 1'b0, 1, 6'b000100, 13'h1FFF, 2, 4);
      // Stale rc_valid during the request pulse must be ignored.
      pkt(16'hBEEF, 1'b1, 2, 6'b100001, 13'h00A5, 1, 2);
      // Back-to-back single-flit packets.
      pkt(16'h0001, 1'b1, 1, 6'b010000, 13'h0003, 1, 1);
      pkt(16'h0002, 1'b0, 1, 6'b000011, 13'h1000, 1, 1);
      // Empty route: drained.
      pkt(16'h0BAD, 1'b0, 1, 6'b000000, 13'h0123, 1, 3);

      // Unanswered routing request: retry cadence depends on the build.
      head_valid = 1'b1;
      header_in  = 16'h5A5A;
      tick();
      head_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
`ifdef VC_ROUTE_REQUESTER_RC_RETRY_EN
         check_eq("retry_rc_req", 32'(rc_req), 32'((i % 16) == 0));
`else
         check_eq("retry_rc_req", 32'(rc_req), 32'(i == 0));
`endif
         check_eq("retry_header", 32'(rc_header), 32'(16'h5A5A));
         tick();
      end
      rc_answer(1, 6'b000000, 13'h0042);
      data_phase(1, 1'b1);

      // Randomised packets.
      for (int p = 0; p < 40; p++) begin
         rv = ($urandom_range(0, 3) == 0) ? 6'b0 : 6'($urandom_range(1, 63));
         pkt(16'($urandom), 1'($urandom), $urandom_range(1, 6), rv, 13'($urandom),
             $urandom_range(1, 4), $urandom_range(1, 5));
      end

      // Asynchronous reset in VA_WAIT.
      send_head(16'hCAFE, 1'b0);
      rc_answer(1, 6'b001000, 13'h0F0F);
      #3 rs = 1'b0;
      #1;
      check_eq("async_va_req", 32'(va_req), 32'(0));
      check_eq("async_busy", 32'(route_busy), 32'(0));
      check_eq("async_rc_req", 32'(rc_req), 32'(0));
      check_eq("async_va_outport", 32'(va_outport), 32'(0));
      check_eq("async_drop_cnt", 32'(drop_cnt), 32'(0));
      exp_drops = 0;
      exp_vo    = '0;
      exp_vv    = '0;
      #2 rs = 1'b1;
      tick();
      pkt(16'h7777, 1'b0, 1, 6'b000001, 13'h0001, 1, 1);
      pkt(16'h8888, 1'b0, 1, 6'b000010, 13'h0002, 1, 1);

      // Drop counter saturation.
      for (int p = 0; p < 300; p++) begin
         pkt(16'($urandom), 1'b0, 1, 6'b0, 13'($urandom), 1, 1);
      end
      check_eq("drop_sat", 32'(drop_cnt), 32'(255));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
